// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receive path.
// Holds the scan-code set 2 prefix bytes, the arrow codes and the frame FSM encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
    localparam logic [7:0] PS2_PREFIX_PAUSE = 8'hE1;

    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Odd parity: data byte plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: synchronises the pins, detects ps2_clk falling edges and
// deframes 11-bit frames into bytes, with a watchdog for stalled frames.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter logic [16:0] TIMEOUT_CYCLES = 17'd100_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output rx_state_t  state
);

    logic        clk_meta, clk_sync, clk_prev;
    logic        dat_meta, dat_sync;
    logic        fall, dat_bit;
    logic [7:0]  shift;
    logic        parity_bit;
    logic [2:0]  bit_cnt;
    logic [16:0] wdog;
    logic        timeout, frame_ok;

    // Edge register: fall and dat_bit are aligned, three clk cycles behind the pins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            fall     <= 1'b0;
            dat_bit  <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
            fall     <= clk_prev & ~clk_sync;
            dat_bit  <= dat_sync;
        end
    end

    assign timeout    = (state != RX_IDLE) && (wdog == TIMEOUT_CYCLES - 17'd1);
    assign frame_ok   = dat_bit && odd_parity_ok(shift, parity_bit);
    assign byte_data  = shift;
    assign byte_valid = fall && (state == RX_STOP) && frame_ok;
    // A real edge always takes priority over a timeout landing in the same cycle.
    assign frame_err  = (fall && (state == RX_STOP) && !frame_ok) || (!fall && timeout);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= RX_IDLE;
            shift      <= 8'h00;
            parity_bit <= 1'b0;
            bit_cnt    <= 3'd0;
            wdog       <= 17'd0;
        end else begin
            if (fall || state == RX_IDLE) wdog <= 17'd0;
            else                          wdog <= wdog + 17'd1;

            if (fall) begin
                case (state)
                    RX_IDLE: begin
                        if (!dat_bit) begin
                            bit_cnt <= 3'd0;
                            state   <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        shift   <= {dat_bit, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        parity_bit <= dat_bit;
                        state      <= RX_STOP;
                    end
                    RX_STOP: state <= RX_IDLE;
                    default: state <= RX_IDLE;
                endcase
            end else if (timeout) begin
                state <= RX_IDLE;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: folds E0/F0 prefixes from the frame receiver into one
// registered key event with a single-cycle key_valid strobe.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter logic [16:0] TIMEOUT_CYCLES = 17'd100_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] keycode,
    output logic       key_make,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err,
    output rx_state_t  rx_state
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;
    logic       ext_flag, brk_flag;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk       (clk),
        .resetn    (resetn),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .byte_data (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_err),
        .state     (rx_state)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            keycode   <= 8'h00;
            key_make  <= 1'b0;
            key_ext   <= 1'b0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (rx_err) begin
                // A broken frame may have been a prefix or the key itself; drop the whole sequence.
                frame_err <= 1'b1;
                ext_flag  <= 1'b0;
                brk_flag  <= 1'b0;
            end else if (rx_valid) begin
                case (rx_byte)
                    PS2_PREFIX_EXT:   ext_flag <= 1'b1;
                    PS2_PREFIX_BREAK: brk_flag <= 1'b1;
                    PS2_PREFIX_PAUSE: begin
                        ext_flag <= 1'b0;
                        brk_flag <= 1'b0;
                    end
                    default: begin
                        keycode   <= rx_byte;
                        key_make  <= !brk_flag;
                        key_ext   <= ext_flag;
                        key_valid <= 1'b1;
                        ext_flag  <= 1'b0;
                        brk_flag  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios from the key-event rules plus a
// randomized byte stream checked against a prefix-folding reference model.
module tb_ps2_key_decoder;
    import ps2_pkg::*;

    localparam int T = 200;

    logic       clk;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] keycode;
    logic       key_make;
    logic       key_ext;
    logic       key_valid;
    logic       frame_err;
    rx_state_t  rx_state;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int last_valid_cyc = 0;
    int last_err_cyc = 0;
    int err_cnt = 0;
    int width_viol = 0;
    int excl_viol = 0;
    logic prev_valid = 1'b0;
    logic prev_err = 1'b0;

    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(17'd200)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .keycode  (keycode),
        .key_make (key_make),
        .key_ext  (key_ext),
        .key_valid(key_valid),
        .frame_err(frame_err),
        .rx_state (rx_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    // monitor: records every event and strobe, sampled 1 time unit after the edge
    always @(posedge clk) begin
        #1;
        if (key_valid) begin
            obs_q.push_back({key_ext, key_make, keycode});
            last_valid_cyc = cyc;
        end
        if (frame_err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (key_valid && frame_err) excl_viol++;
        if ((key_valid && prev_valid) || (frame_err && prev_err)) width_viol++;
        prev_valid = key_valid;
        prev_err = frame_err;
    end

    // driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_clk(10);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_clk(20);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_parity);
        logic par;
        par = ~(^b) ^ bad_parity;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(1'b1);
        wait_clk(30);
    endtask

    // tests
    task automatic test_reset();
        resetn = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_clk(5);
        chk_cnt++; if ({keycode, key_make, key_ext, key_valid, frame_err} !== 12'h000) $display("FAIL reset_outputs_in_reset: got %h want 000", {keycode, key_make, key_ext, key_valid, frame_err}); else pass_cnt++;
        resetn = 1'b1;
        wait_clk(20);
        chk_cnt++; if (keycode !== 8'h00) $display("FAIL reset_keycode: got %h want 00", keycode); else pass_cnt++;
        chk_cnt++; if ({key_make, key_ext} !== 2'b00) $display("FAIL reset_make_ext: got %b want 00", {key_make, key_ext}); else pass_cnt++;
        chk_cnt++; if (rx_state !== RX_IDLE) $display("FAIL reset_state: got %0d want %0d", rx_state, RX_IDLE); else pass_cnt++;
        chk_cnt++; if (obs_q.size() + err_cnt !== 0) $display("FAIL reset_no_strobe: got %0d want 0", obs_q.size() + err_cnt); else pass_cnt++;
    endtask

    task automatic test_arrow_make();
        obs_q.delete();
        send_frame(8'hE0, 1'b0);
        chk_cnt++; if (obs_q.size() !== 0) $display("FAIL e0_alone_no_event: got %0d want 0", obs_q.size()); else pass_cnt++;
        send_frame(8'h6B, 1'b0);
        chk_cnt++; if (obs_q.size() !== 1) $display("FAIL e0_6b_count: got %0d want 1", obs_q.size()); else pass_cnt++;
        if (obs_q.size() > 0) begin
            chk_cnt++; if (obs_q[0] !== {1'b1, 1'b1, 8'h6B}) $display("FAIL e0_6b_event: got %h want %h", obs_q[0], {1'b1, 1'b1, 8'h6B}); else pass_cnt++;
        end
        // stop-bit pin fall -> 3 cycles detect -> strobe on following edge
        chk_cnt++; if (last_valid_cyc !== last_fall_cyc + 4) $display("FAIL valid_latency: got %0d want %0d", last_valid_cyc - last_fall_cyc, 4); else pass_cnt++;
        chk_cnt++; if ({key_ext, key_make, keycode} !== {1'b1, 1'b1, 8'h6B}) $display("FAIL e0_6b_held: got %h want %h", {key_ext, key_make, keycode}, {1'b1, 1'b1, 8'h6B}); else pass_cnt++;
    endtask

    task automatic test_ext_break();
        obs_q.delete();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h6B, 1'b0);
        chk_cnt++; if (obs_q.size() !== 1) $display("FAIL e0_f0_6b_count: got %0d want 1", obs_q.size()); else pass_cnt++;
        if (obs_q.size() > 0) begin
            chk_cnt++; if (obs_q[0] !== {1'b1, 1'b0, 8'h6B}) $display("FAIL e0_f0_6b_event: got %h want %h", obs_q[0], {1'b1, 1'b0, 8'h6B}); else pass_cnt++;
        end
        chk_cnt++; if (key_valid !== 1'b0) $display("FAIL valid_dropped: got %b want 0", key_valid); else pass_cnt++;
    endtask

    task automatic test_plain();
        obs_q.delete();
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        chk_cnt++; if (obs_q.size() !== 2) $display("FAIL plain_count: got %0d want 2", obs_q.size()); else pass_cnt++;
        if (obs_q.size() > 1) begin
            chk_cnt++; if (obs_q[0] !== {1'b0, 1'b1, 8'h1C}) $display("FAIL plain_make: got %h want %h", obs_q[0], {1'b0, 1'b1, 8'h1C}); else pass_cnt++;
            chk_cnt++; if (obs_q[1] !== {1'b0, 1'b0, 8'h1C}) $display("FAIL plain_break: got %h want %h", obs_q[1], {1'b0, 1'b0, 8'h1C}); else pass_cnt++;
        end
    endtask

    task automatic test_parity_error();
        int base_err;
        obs_q.delete();
        base_err = err_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b1);
        chk_cnt++; if (err_cnt !== base_err + 1) $display("FAIL parity_err_count: got %0d want %0d", err_cnt - base_err, 1); else pass_cnt++;
        chk_cnt++; if (obs_q.size() !== 0) $display("FAIL parity_no_event: got %0d want 0", obs_q.size()); else pass_cnt++;
        chk_cnt++; if ({key_ext, key_make, keycode} !== {1'b0, 1'b0, 8'h1C}) $display("FAIL parity_outputs_held: got %h want %h", {key_ext, key_make, keycode}, {1'b0, 1'b0, 8'h1C}); else pass_cnt++;
        send_frame(8'h6B, 1'b0);
        chk_cnt++; if (obs_q.size() !== 1) $display("FAIL after_err_count: got %0d want 1", obs_q.size()); else pass_cnt++;
        if (obs_q.size() > 0) begin
            chk_cnt++; if (obs_q[0] !== {1'b0, 1'b1, 8'h6B}) $display("FAIL after_err_ext_cleared: got %h want %h", obs_q[0], {1'b0, 1'b1, 8'h6B}); else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
        int base_err;
        int fall5;
        logic [7:0] b;
        b = 8'hA5;
        obs_q.delete();
        send_frame(8'hE0, 1'b0);
        base_err = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        fall5 = last_fall_cyc;
        ps2_dat = 1'b1;
        wait_clk(T + 40);
        chk_cnt++; if (err_cnt !== base_err + 1) $display("FAIL timeout_err_count: got %0d want 1", err_cnt - base_err); else pass_cnt++;
        chk_cnt++; if (last_err_cyc !== fall5 + 4 + T) $display("FAIL timeout_latency: got %0d want %0d", last_err_cyc - fall5 - 4, T); else pass_cnt++;
        chk_cnt++; if (rx_state !== RX_IDLE) $display("FAIL timeout_state: got %0d want %0d", rx_state, RX_IDLE); else pass_cnt++;
        send_frame(8'h75, 1'b0);
        chk_cnt++; if (obs_q.size() !== 1) $display("FAIL after_timeout_count: got %0d want 1", obs_q.size()); else pass_cnt++;
        if (obs_q.size() > 0) begin
            chk_cnt++; if (obs_q[0] !== {1'b0, 1'b1, 8'h75}) $display("FAIL after_timeout_event: got %h want %h", obs_q[0], {1'b0, 1'b1, 8'h75}); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int base_err;
        logic [7:0] b;
        b = 8'hE0;
        obs_q.delete();
        base_err = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        wait_clk(5);
        resetn = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_clk(5);
        resetn = 1'b1;
        wait_clk(T + 40);
        chk_cnt++; if ({key_ext, key_make, keycode} !== 10'h000) $display("FAIL midreset_outputs: got %h want 000", {key_ext, key_make, keycode}); else pass_cnt++;
        chk_cnt++; if (obs_q.size() + (err_cnt - base_err) !== 0) $display("FAIL midreset_no_strobe: got %0d want 0", obs_q.size() + (err_cnt - base_err)); else pass_cnt++;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h74, 1'b0);
        chk_cnt++; if (obs_q.size() !== 1) $display("FAIL midreset_after_count: got %0d want 1", obs_q.size()); else pass_cnt++;
        if (obs_q.size() > 0) begin
            chk_cnt++; if (obs_q[0] !== {1'b1, 1'b1, 8'h74}) $display("FAIL midreset_after_event: got %h want %h", obs_q[0], {1'b1, 1'b1, 8'h74}); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic bad;
        logic m_ext, m_brk;
        int base_err, exp_err, n;
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_err = 0;
        base_err = err_cnt;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                default: b = 8'($urandom_range(0, 255));
            endcase
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, bad);
            // reference: a key event is the non-prefix byte tagged with whatever prefixes led up to it
            if (bad) begin
                exp_err++;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (b == 8'hE0) begin
                m_ext = 1'b1;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else if (b == 8'hE1) begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else begin
                exp_q.push_back({m_ext, ~m_brk, b});
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
        chk_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL rand_event_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
        chk_cnt++; if (err_cnt - base_err !== exp_err) $display("FAIL rand_err_count: got %0d want %0d", err_cnt - base_err, exp_err); else pass_cnt++;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk_cnt++; if (obs_q[i] !== exp_q[i]) $display("FAIL rand_event_%0d: got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
        end
        if (exp_q.size() > 0) begin
            chk_cnt++; if ({key_ext, key_make, keycode} !== exp_q[exp_q.size() - 1]) $display("FAIL rand_held: got %h want %h", {key_ext, key_make, keycode}, exp_q[exp_q.size() - 1]); else pass_cnt++;
        end
    endtask

    task automatic test_strobe_rules();
        chk_cnt++; if (width_viol !== 0) $display("FAIL strobe_width: got %0d want 0", width_viol); else pass_cnt++;
        chk_cnt++; if (excl_viol !== 0) $display("FAIL strobe_exclusive: got %0d want 0", excl_viol); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_arrow_make();
        test_ext_break();
        test_plain();
        test_parity_error();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        test_strobe_rules();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the raw PS/2 keyboard line pair, deframes 11-bit frames, and folds the scan-code set 2 prefixes E0 (extended) and F0 (break) into one key event. Each event is presented as `keycode`, `key_make` and `key_ext`, qualified by a one-cycle `key_valid` strobe. It sits directly upstream of the game datapath, which latches `keycode` when `key_ext && key_make`. Arrow keys are E0-prefixed make codes 6B/74/75/72.

## Interface
- `TIMEOUT_CYCLES`, default 17'd100_000: maximum `clk` cycles allowed between consecutive `ps2_clk` falling edges inside a frame (2 ms at 50 MHz).
- `clk`  in  1  system clock, 50 MHz.
- `resetn`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin; asynchronous; idles high.
- `ps2_dat`  in  1  raw PS/2 data pin; asynchronous; idles high.
- `keycode`  out  8  last decoded non-prefix scan byte; held until the next event.
- `key_make`  out  1  1 = press, 0 = release (F0 seen); held.
- `key_ext`  out  1  1 = E0 prefix preceded the byte; held.
- `key_valid`  out  1  one-cycle strobe; the three outputs above changed this cycle.
- `frame_err`  out  1  one-cycle strobe on a parity error, stop-bit error or timeout.

## Operation
- **Synchronisation**
  - `ps2_clk` and `ps2_dat` each pass through a 2-FF synchroniser; both flops reset to 1.
  - A falling edge is prev_sync=1 and sync=0. Data is sampled from synced `ps2_dat` in the same cycle.
- **Frame FSM** (IDLE, DATA, PARITY, STOP), advancing only on a falling edge:
  - IDLE: if dat=0, clear the 3-bit bit counter and go to DATA. If dat=1, stay in IDLE (glitch, no error).
  - DATA: shift dat into bit 7 of the shift register (LSB first). After the 8th bit, go to PARITY.
  - PARITY: store dat, go to STOP.
  - STOP: the frame is good if dat=1 and XOR(byte, parity)=1 (odd parity). Otherwise pulse `frame_err`. Always return to IDLE.
- **Watchdog**
  - Counter clears on every falling edge and while in IDLE; it counts in every other state.
  - On reaching TIMEOUT_CYCLES: go to IDLE, pulse `frame_err`, clear the prefix flags.
- **Prefix layer**, acting on each good byte:
  - E0: set ext_flag, no event.
  - F0: set brk_flag, no event.
  - E1: clear both flags, no event. Pause-key bytes that follow decode as ordinary codes; this is a documented limitation.
  - Any other byte: `keycode`=byte, `key_make`=!brk_flag, `key_ext`=ext_flag, pulse `key_valid`, clear both flags.
- **Errors**
  - Any `frame_err` clears both flags and leaves `keycode`, `key_make` and `key_ext` unchanged.
- **Reset values**
  - All outputs are 0.
  - FSM in IDLE; flags, counters and shift register cleared.
  - Asserting reset mid-frame discards the partial frame immediately; no strobe is produced.

## Timing
- Pin-to-detect latency is 3 `clk` cycles: 2 synchroniser stages plus the edge register.
- `key_valid` or `frame_err` rises on the `clk` edge after the cycle in which the 11th falling edge (stop bit) is detected. Each is high for exactly 1 cycle, and they are mutually exclusive.
- Outputs update on the same edge as `key_valid` and are stable until the next `key_valid`.
- No back-pressure: the consumer must sample during the strobe, or use the held levels.
- The minimum spacing between events is one PS/2 frame (about 1.1 ms at 10 kHz), so there is no overrun path.
- The watchdog fires exactly TIMEOUT_CYCLES cycles after the last in-frame falling edge.
- An edge and the timeout landing in the same cycle: the edge wins.

## Structure
- Shared package `ps2_pkg`:
  - PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BREAK=8'hF0, PS2_PREFIX_PAUSE=8'hE1.
  - Arrow codes KEY_LEFT=8'h6B, KEY_RIGHT=8'h74, KEY_UP=8'h75, KEY_DOWN=8'h72; the datapath switches to these.
  - FSM state encoding.
- Sub-module `ps2_frame_rx`: synchroniser, edge detect, frame FSM and watchdog. It outputs `byte_data[7:0]`, a `byte_valid` strobe and a `frame_err` strobe.
- The top level adds the prefix layer and output registers.

## Test plan
All bursts at 10 kHz PS/2 clock unless stated.
- E0, 6B → one `key_valid`; `keycode`=6B, `key_make`=1, `key_ext`=1. No strobe after the E0 frame alone.
- E0, F0, 6B → `keycode`=6B, `key_make`=0, `key_ext`=1; exactly one `key_valid` across the three frames.
- 1C → `keycode`=1C, `key_make`=1, `key_ext`=0. Then F0, 1C → `key_make`=0, `key_ext`=0.
- E0, then 6B with the parity bit inverted → `frame_err` pulse, no `key_valid`, outputs unchanged. A following clean 6B → `key_ext`=0 (flag was cleared).
- With TIMEOUT_CYCLES=200: send start bit plus 4 data bits, then stall → `frame_err` exactly 200 cycles after the 5th edge, FSM in IDLE. A following 75 decodes correctly.
- Assert `resetn` low after bit 3 of an E0 frame, then release → all outputs 0, no strobe. A subsequent E0, 74 → `keycode`=74, `key_ext`=1.
